data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache that serves the CPU's MemRead/MemWrite load/store requests and drives the backing data memory. It sits between the datapath's memory stage and data memory. It raises a stall toward the pipeline for every access until that access completes. Reads fill a whole 4-word line; writes go through to memory word by word.

## Interface
- LINES, 4: number of cache lines; power of two; index width log2(LINES).
- WORD, 16: data word width; addresses are 16-bit word addresses.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_read  in  1  load request (MemRead); held until cpu_done.
- cpu_write  in  1  store request (MemWrite); held until cpu_done.
- cpu_addr  in  16  word address; held stable with the request.
- cpu_wdata  in  16  store data; held stable with the request.
- cpu_rdata  out  16  load data; valid in the cpu_done cycle.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  = (cpu_read | cpu_write) & ~cpu_done, combinational.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  1 = word write, 0 = line read.
- mem_addr  out  16  line-aligned address on reads ([1:0]=0); full word address on writes.
- mem_wdata  out  16  write-through data.
- mem_rdata  in  64  fill line; word 0 in [15:0], word 3 in [63:48].
- mem_ready  in  1  memory done; mem_rdata valid in the same cycle.
- hit_count  out  16  accesses that hit since reset.
- miss_count  out  16  accesses that missed since reset.

## Operation
- Address split: offset = addr[1:0]; index = addr[1+log2(LINES):2]; tag = the remaining upper bits.
- Storage per line: valid bit, tag, and 4 data words.
- FSM states: IDLE, LOOKUP, FILL, WTHRU, RESP.
- IDLE: on a request, latch addr, wdata and kind, then go to LOOKUP. If cpu_read and cpu_write are both high, the access is a write.
- LOOKUP: hit = valid & tag match.
  - Read hit: load the word into cpu_rdata; go to RESP.
  - Read miss: go to FILL.
  - Write, hit or miss: if hit, update the cached word; go to WTHRU.
  - Increment hit_count or miss_count once per access, in this state only.
- FILL: mem_req=1, mem_we=0, mem_addr={addr[15:2],2'b00}.
  - On mem_ready: write the line, tag and valid=1; load cpu_rdata from mem_rdata at the offset; go to RESP.
- WTHRU: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata. A write miss allocates nothing.
  - On mem_ready: go to RESP.
- RESP: cpu_done=1 for exactly one cycle, then go to IDLE. cpu_rdata holds its value until the next read completes.
- Counters wrap modulo 2^16.
- Reset:
  - State IDLE; all valid bits cleared.
  - cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
  - Data and tag arrays are not cleared.

## Timing
- Registered outputs: cpu_done, cpu_rdata, mem_*.
- mem_req rises in the cycle after LOOKUP. It stays high, with address and data stable, until the cycle mem_ready is sampled high. It drops in the following cycle.
- Hit: request first sampled in cycle N → cpu_done high in cycle N+2.
- Miss or any write: with mem_ready in cycle M → cpu_done high in cycle M+1.
- cpu_stall is high in every cycle of a pending request except the cpu_done cycle.
- A request still asserted in the cycle after cpu_done is treated as a new access. The pipeline advances on the done edge, so the next request is normally a different one.
- Request inputs are ignored outside IDLE.
- mem_ready outside FILL/WTHRU is ignored.
- Reset mid-FILL/WTHRU: abort; mem_req is 0 the cycle after reset; no line is written; no cpu_done.
- Back-to-back reads of the same line: the first misses, the second hits.
- A write hit updates the cache in LOOKUP, so a read issued after its cpu_done returns the new value.

## Test plan
- Read 0x0012 after reset, memory returns 0x4444_3333_2222_1111 after 3 cycles → exactly one mem_req line read at 0x0010; cpu_rdata=0x3333; miss_count=1.
- Read 0x0013 next → hit in 2 cycles, no mem_req, cpu_rdata=0x4444, hit_count=1.
- Write 0xBEEF to 0x0011, then read 0x0011 → write-through with mem_we=1, mem_addr=0x0011, mem_wdata=0xBEEF; the read hits and returns 0xBEEF.
- Write to 0x0050 (miss), then read 0x0050 → write goes through and does not allocate; the read misses and fills.
- Conflict: read 0x0012, then 0x0052 (same index, LINES=4) → both miss; re-reading 0x0012 misses again.
- Reset asserted during a FILL wait → mem_req=0 next cycle, all outputs at reset values; the following read of the same address misses.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Serves one load/store at a time and stalls the pipeline until cpu_done pulses.
module data_cache #(
    parameter int LINES = 4,
    parameter int WORD  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [15:0]       cpu_addr,
    input  logic [WORD-1:0]   cpu_wdata,
    output logic [WORD-1:0]   cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    input  logic [4*WORD-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 16 - 2 - IW;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WTHRU, S_RESP} state_t;
    state_t r_state, w_state_next;

    logic [15:0]       r_addr;
    logic [WORD-1:0]   r_wdata;
    logic              r_is_write;
    logic [LINES-1:0]  r_valid;
    logic [TW-1:0]     r_tag [LINES];
    logic [WORD-1:0]   r_rdata;
    logic              r_done;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [15:0]       r_mem_addr;
    logic [WORD-1:0]   r_mem_wdata;
    logic [15:0]       r_hits;
    logic [15:0]       r_misses;

    logic [IW-1:0]     w_index;
    logic [1:0]        w_offset;
    logic [TW-1:0]     w_tag;
    logic              w_hit;
    logic              w_fill;
    logic [4*WORD-1:0] w_line_rd;

    assign w_offset = r_addr[1:0];
    assign w_index  = r_addr[IW+1:2];
    assign w_tag    = r_addr[15:IW+2];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_fill   = (r_state == S_FILL) && mem_ready;

    assign cpu_rdata  = r_rdata;
    assign cpu_done   = r_done;
    assign cpu_stall  = (cpu_read | cpu_write) & ~r_done;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    // One storage column per word of the line; a fill writes all four, a write hit only one.
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        logic [WORD-1:0] r_word [LINES];
        logic            w_wr_hit;

        assign w_wr_hit = (r_state == S_LOOKUP) && r_is_write && w_hit && (w_offset == 2'(gi));

        always_ff @(posedge clk) begin
            if (!reset && w_fill) begin
                r_word[w_index] <= mem_rdata[gi*WORD +: WORD];
            end else if (!reset && w_wr_hit) begin
                r_word[w_index] <= r_wdata;
            end
        end

        assign w_line_rd[gi*WORD +: WORD] = r_word[w_index];
    end

    always_ff @(posedge clk) begin
        if (!reset && w_fill) begin
            r_tag[w_index] <= w_tag;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_read || cpu_write) w_state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (r_is_write)  w_state_next = S_WTHRU;
                else if (w_hit)  w_state_next = S_RESP;
                else             w_state_next = S_FILL;
            end
            S_FILL:   if (mem_ready) w_state_next = S_RESP;
            S_WTHRU:  if (mem_ready) w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_done    <= (w_state_next == S_RESP);
            // Request stays up for the whole FILL/WTHRU stay and drops after mem_ready.
            r_mem_req <= (w_state_next == S_FILL) || (w_state_next == S_WTHRU);
            case (r_state)
                S_IDLE: begin
                    if (cpu_read || cpu_write) begin
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_is_write <= cpu_write;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) r_hits   <= r_hits + 16'd1;
                    else       r_misses <= r_misses + 16'd1;
                    if (r_is_write) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                    end else if (w_hit) begin
                        r_rdata <= w_line_rd[w_offset*WORD +: WORD];
                    end else begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_addr[15:2], 2'b00};
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_rdata          <= mem_rdata[w_offset*WORD +: WORD];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: memory responder with adjustable latency,
// expected access results queued per scenario and compared as each access completes.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count, miss_count;

    data_cache #(.LINES(4), .WORD(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mtx_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic [7:0]  lat;
        logic [7:0]  nmem;
        logic        mwe;
        logic [15:0] maddr;
        logic [15:0] mwdata;
        logic [15:0] hits;
        logic [15:0] misses;
        logic [7:0]  hs_err;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        obs_t        e;
    } acc_t;

    logic [15:0] mem_model [0:65535];
    mtx_t        obs_mem_q [$];
    acc_t        sb_q [$];
    int          mem_lat = 3;
    bit          ready_en = 1'b1;
    int          stab_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_hits = 16'd0;
    logic [15:0] exp_misses = 16'd0;
    logic [15:0] exp_last_rd = 16'd0;

    // Memory responder: logs each request, checks it stays stable, answers after mem_lat cycles.
    initial begin
        bit   busy;
        int   wcnt;
        mtx_t cur;
        busy = 1'b0; wcnt = 0; cur = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = {$urandom(), $urandom()};
            if (mem_req !== 1'b1) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = mem_lat;
                    cur.we = mem_we;
                    cur.addr = mem_addr;
                    cur.wdata = mem_we ? mem_wdata : 16'h0;
                    obs_mem_q.push_back(cur);
                end else begin
                    if (mem_we !== cur.we || mem_addr !== cur.addr || (mem_we && mem_wdata !== cur.wdata))
                        stab_err++;
                    if (wcnt > 0) wcnt--;
                end
                if (wcnt == 0 && ready_en) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = {mem_model[{mem_addr[15:2], 2'd3}], mem_model[{mem_addr[15:2], 2'd2}],
                                      mem_model[{mem_addr[15:2], 2'd1}], mem_model[{mem_addr[15:2], 2'd0}]};
                    busy = 1'b0;
                end
            end
        end
    end

    function automatic string fmt(obs_t o);
        return $sformatf("rd=%h lat=%0d nmem=%0d we=%b maddr=%h mwd=%h hits=%0d misses=%0d hs_err=%0d",
                         o.rdata, o.lat, o.nmem, o.mwe, o.maddr, o.mwdata, o.hits, o.misses, o.hs_err);
    endfunction

    // Queue an access with its expected outcome, derived from hit/miss and the protocol timing.
    task automatic push_acc(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                            input logic hit, input logic [15:0] rd);
        acc_t x;
        x = '0;
        x.wr = wr; x.addr = a; x.wdata = wd;
        if (hit) exp_hits = exp_hits + 16'd1;
        else     exp_misses = exp_misses + 16'd1;
        if (!wr) exp_last_rd = rd;
        x.e.rdata  = exp_last_rd;
        x.e.nmem   = (wr || !hit) ? 8'd1 : 8'd0;
        x.e.lat    = (wr || !hit) ? 8'(3 + mem_lat) : 8'd2;
        x.e.mwe    = wr;
        x.e.maddr  = (!wr && hit) ? 16'h0 : (wr ? a : {a[15:2], 2'b00});
        x.e.mwdata = wr ? wd : 16'h0;
        x.e.hits   = exp_hits;
        x.e.misses = exp_misses;
        x.e.hs_err = 8'd0;
        sb_q.push_back(x);
    endtask

    task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] wd, output obs_t o);
        int   start;
        bit   done;
        mtx_t m;
        o = '0; done = 1'b0;
        cpu_read = !wr; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        start = cyc;
        #1;
        if (cpu_stall !== 1'b1) o.hs_err = o.hs_err + 8'd1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk); #1;
            if (cpu_done === 1'b1) done = 1'b1;
            else if (cpu_stall !== 1'b1) o.hs_err = o.hs_err + 8'd1;
        end
        o.lat = done ? 8'(cyc - start) : 8'hFF;
        if (done && cpu_stall !== 1'b0) o.hs_err = o.hs_err + 8'd1;
        o.rdata = cpu_rdata; o.hits = hit_count; o.misses = miss_count;
        cpu_read = 1'b0; cpu_write = 1'b0;
        o.nmem = 8'(obs_mem_q.size());
        if (obs_mem_q.size() > 0) begin
            m = obs_mem_q.pop_front();
            o.mwe = m.we; o.maddr = m.addr; o.mwdata = m.wdata;
        end
        obs_mem_q.delete();
        @(posedge clk); #1;
        if (cpu_done !== 1'b0) o.hs_err = o.hs_err + 8'd1;
    endtask

    task automatic test_reset();
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cpu_done, cpu_stall, mem_req, mem_we} !== 4'b0)
            $display("FAIL reset_ctrl: got done/stall/req/we=%b want 0000", {cpu_done, cpu_stall, mem_req, mem_we});
        else n_pass++;
        n_checks++;
        if ({cpu_rdata, mem_addr, mem_wdata} !== 48'h0)
            $display("FAIL reset_data: got rdata=%h maddr=%h mwdata=%h want 0", cpu_rdata, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if ({hit_count, miss_count} !== 32'h0)
            $display("FAIL reset_counts: got hits=%0d misses=%0d want 0", hit_count, miss_count);
        else n_pass++;
        $display("reset: outputs checked");
        reset = 1'b0;
    endtask

    task automatic test_read_miss_hit();
        obs_t o; acc_t a;
        mem_lat = 3;
        push_acc(1'b0, 16'h0012, 16'h0, 1'b0, 16'h3333);
        push_acc(1'b0, 16'h0013, 16'h0, 1'b1, 16'h4444);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL read_miss_hit %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("read_miss_hit %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
    endtask

    task automatic test_write_hit();
        obs_t o; acc_t a;
        mem_lat = 3;
        push_acc(1'b1, 16'h0011, 16'hBEEF, 1'b1, 16'h0);
        push_acc(1'b0, 16'h0011, 16'h0, 1'b1, 16'hBEEF);
        push_acc(1'b0, 16'h0010, 16'h0, 1'b1, 16'h1111);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL write_hit %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("write_hit %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
    endtask

    task automatic test_write_no_alloc();
        obs_t o; acc_t a;
        mem_lat = 1;
        push_acc(1'b1, 16'h0050, 16'h1234, 1'b0, 16'h0);
        push_acc(1'b0, 16'h0050, 16'h0, 1'b0, 16'h1234);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL write_no_alloc %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("write_no_alloc %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
    endtask

    task automatic test_conflict();
        obs_t o; acc_t a;
        mem_lat = 2;
        push_acc(1'b0, 16'h0012, 16'h0, 1'b0, 16'h3333);
        push_acc(1'b0, 16'h0052, 16'h0, 1'b0, 16'h9C52);
        push_acc(1'b0, 16'h0012, 16'h0, 1'b0, 16'h3333);
        push_acc(1'b0, 16'h0011, 16'h0, 1'b1, 16'hBEEF);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL conflict %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("conflict %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; acc_t a;
        mem_lat = 0;
        push_acc(1'b0, 16'h0024, 16'h0, 1'b0, 16'h9C24);
        push_acc(1'b0, 16'h0027, 16'h0, 1'b1, 16'h9C27);
        push_acc(1'b1, 16'h0026, 16'h0F0F, 1'b1, 16'h0);
        push_acc(1'b0, 16'h0026, 16'h0, 1'b1, 16'h0F0F);
        push_acc(1'b0, 16'hFFFE, 16'h0, 1'b0, 16'h63FE);
        push_acc(1'b0, 16'h0025, 16'h0, 1'b1, 16'h9C25);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL back_to_back %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("back_to_back %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
    endtask

    task automatic test_reset_mid_fill();
        obs_t o; acc_t a; bit seen; mtx_t m;
        mem_lat = 3; ready_en = 1'b0; seen = 1'b0;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0030;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            seen = (mem_req === 1'b1);
        end
        n_checks++;
        if (!seen) $display("FAIL rst_fill_req: got mem_req=%b want 1 within 20 cycles", mem_req);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; cpu_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({cpu_done, cpu_stall, mem_req, mem_we} !== 4'b0)
            $display("FAIL rst_fill_ctrl: got done/stall/req/we=%b want 0000", {cpu_done, cpu_stall, mem_req, mem_we});
        else n_pass++;
        n_checks++;
        if ({cpu_rdata, mem_addr, mem_wdata} !== 48'h0)
            $display("FAIL rst_fill_data: got rdata=%h maddr=%h mwdata=%h want 0", cpu_rdata, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if ({hit_count, miss_count} !== 32'h0)
            $display("FAIL rst_fill_counts: got hits=%0d misses=%0d want 0", hit_count, miss_count);
        else n_pass++;
        m = (obs_mem_q.size() > 0) ? obs_mem_q[0] : '1;
        n_checks++;
        if ({8'(obs_mem_q.size()), m.we, m.addr} !== {8'd1, 1'b0, 16'h0030})
            $display("FAIL rst_fill_memreq: got n=%0d we=%b addr=%h want n=1 we=0 addr=0030", obs_mem_q.size(), m.we, m.addr);
        else n_pass++;
        obs_mem_q.delete();
        $display("reset_mid_fill: aborted fill checked");
        ready_en = 1'b1;
        exp_hits = 16'd0; exp_misses = 16'd0; exp_last_rd = 16'd0;
        push_acc(1'b0, 16'h0030, 16'h0, 1'b0, 16'h9C30);
        push_acc(1'b0, 16'h0025, 16'h0, 1'b0, 16'h9C25);
        push_acc(1'b0, 16'h0026, 16'h0, 1'b1, 16'h0F0F);
        while (sb_q.size() > 0) begin
            a = sb_q.pop_front();
            do_access(a.wr, a.addr, a.wdata, o);
            n_checks++;
            if (o !== a.e) $display("FAIL reset_mid_fill %s %h: got %s want %s", a.wr ? "W" : "R", a.addr, fmt(o), fmt(a.e));
            else begin n_pass++; $display("reset_mid_fill %s %h: %s", a.wr ? "W" : "R", a.addr, fmt(o)); end
        end
        n_checks++;
        if (stab_err !== 0) $display("FAIL mem_stable: got %0d unstable request cycles want 0", stab_err);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = 16'(i) ^ 16'h9C00;
        mem_model[16'h0010] = 16'h1111;
        mem_model[16'h0011] = 16'h2222;
        mem_model[16'h0012] = 16'h3333;
        mem_model[16'h0013] = 16'h4444;
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_write_no_alloc();
        test_conflict();
        test_back_to_back();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
